// File: rtl/pc_trace_buffer.sv
// Circular PC/instruction trace buffer: captures until a trigger plus POST_TRIG
// samples, freezes, then drains the history oldest-first through a pop port.
module pc_trace_buffer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_valid,
  input  logic [DATA_W-1:0]        cap_pc,
  input  logic [DATA_W-1:0]        cap_inst,
  input  logic                     trig,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_inst,
  output logic [1:0]               state_o,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 2 * DATA_W;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    POST  = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   post_cnt;
  logic [EW-1:0]   mem [DEPTH];

  logic            wr_en_c, pop_c, full_c, post_last_c, rearm_c;
  logic [EW-1:0]   rd_entry_c;

  assign wr_en_c     = (state != DONE) && cap_valid;
  assign pop_c       = (state == DONE) && rd_req && (count != '0);
  assign full_c      = (count == CW'(DEPTH));
  assign post_last_c = ((post_cnt + CW'(1)) == CW'(POST_TRIG));
  assign rearm_c     = pop_c && (count == CW'(1));
  assign rd_entry_c  = mem[rd_ptr];
  assign state_o     = 2'(state);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARMED;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ARMED: if (trig) state_nxt = (POST_TRIG == 0) ? DONE : POST;
      POST:  if (cap_valid && post_last_c) state_nxt = DONE;
      DONE:  if (rearm_c) state_nxt = ARMED;
      default: state_nxt = ARMED;
    endcase
  end

  // Storage: no reset, contents are meaningless until written
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= {cap_pc, cap_inst};
  end

  // Pointers, occupancy and post-trigger counter; a write into a full buffer drops the oldest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (full_c) rd_ptr <= rd_ptr + AW'(1);
        else        count  <= count + CW'(1);
      end else if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count - CW'(1);
      end
      if (state == POST && cap_valid) post_cnt <= post_cnt + CW'(1);
      else if (rearm_c)               post_cnt <= '0;
    end
  end

  // Read port: one-cycle latency, data holds between pops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_pc    <= '0;
      rd_inst  <= '0;
    end else begin
      rd_valid <= pop_c;
      if (pop_c) begin
        rd_pc   <= rd_entry_c[EW-1:DATA_W];
        rd_inst <= rd_entry_c[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Randomized bench for pc_trace_buffer checked every cycle against a queue-based model.
module tb_pc_trace_buffer;

  localparam int DEPTH     = 16;
  localparam int DATA_W    = 32;
  localparam int POST_TRIG = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cap_valid = 1'b0;
  logic [DATA_W-1:0] cap_pc = '0;
  logic [DATA_W-1:0] cap_inst = '0;
  logic              trig = 1'b0;
  logic              rd_req = 1'b0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_pc, rd_inst;
  logic [1:0]        state_o;
  logic [4:0]        count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0/1/2, entries held oldest-first in a queue
  int                m_mode = 0;
  int                m_post = 0;
  logic [63:0]       m_q[$];
  logic              m_rd_valid = 1'b0;
  logic [DATA_W-1:0] m_pc = '0, m_inst = '0;

  pc_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_inst(cap_inst),
    .trig(trig), .rd_req(rd_req), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst),
    .state_o(state_o), .count(count)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    m_mode = 0; m_post = 0; m_q.delete();
    m_rd_valid = 1'b0; m_pc = '0; m_inst = '0;
  endfunction

  function automatic void model_step(input logic cv, input logic [31:0] pc, input logic [31:0] inst,
                                     input logic tg, input logic rq);
    logic [63:0] e;
    m_rd_valid = 1'b0;
    if (m_mode != 2 && cv) begin
      m_q.push_back({pc, inst});
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
    end
    if (m_mode == 0) begin
      if (tg) m_mode = (POST_TRIG == 0) ? 2 : 1;
    end else if (m_mode == 1) begin
      if (cv) begin
        m_post++;
        if (m_post == POST_TRIG) m_mode = 2;
      end
    end else begin
      if (rq && m_q.size() > 0) begin
        e = m_q.pop_front();
        m_rd_valid = 1'b1;
        m_pc = e[63:32];
        m_inst = e[31:0];
        if (m_q.size() == 0) begin
          m_mode = 0;
          m_post = 0;
        end
      end
    end
  endfunction

  // One clock of stimulus; all observable outputs compared against the model
  task automatic step(input logic cv, input logic [31:0] pc, input logic [31:0] inst,
                      input logic tg, input logic rq);
    cap_valid = cv; cap_pc = pc; cap_inst = inst; trig = tg; rd_req = rq;
    model_step(cv, pc, inst, tg, rq);
    @(posedge clk);
    #1;
    vectors++;
    if (state_o !== 2'(m_mode)) begin
      miscompares++;
      $display("FAIL state_o @%0t: got %0d expected %0d", $time, state_o, m_mode);
    end
    vectors++;
    if (count !== 5'(m_q.size())) begin
      miscompares++;
      $display("FAIL count @%0t: got %0d expected %0d", $time, count, m_q.size());
    end
    vectors++;
    if (rd_valid !== m_rd_valid) begin
      miscompares++;
      $display("FAIL rd_valid @%0t: got %b expected %b", $time, rd_valid, m_rd_valid);
    end
    vectors++;
    if (rd_pc !== m_pc || rd_inst !== m_inst) begin
      miscompares++;
      $display("FAIL rd_data @%0t: got %h/%h expected %h/%h", $time, rd_pc, rd_inst, m_pc, m_inst);
    end
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Async reset mid-cycle; outputs must clear before any clock edge
  task automatic apply_reset(input string tag);
    cap_valid = 1'b0; trig = 1'b0; rd_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (state_o !== 2'd0 || count !== 5'd0 || rd_valid !== 1'b0 || rd_pc !== '0 || rd_inst !== '0) begin
      miscompares++;
      $display("FAIL reset_%s: got state=%0d count=%0d rd_valid=%b rd_pc=%h expected 0/0/0/0",
               tag, state_o, count, rd_valid, rd_pc);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), $urandom, i == 2, 1'b0);
    apply_reset("mid_post");
    idle();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 14; i++) step(1'b1, 32'(4 * i), $urandom, i == 5, 1'b0);
    vectors++;
    if (state_o !== 2'd2 || count !== 5'd14) begin
      miscompares++;
      $display("FAIL basic_done: got state=%0d count=%0d expected 2/14", state_o, count);
    end
    for (int i = 0; i < 14; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      vectors++;
      if (rd_pc !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL basic_pop%0d: got pc=%0d expected %0d", i, rd_pc, 4 * i);
      end
    end
    vectors++;
    if (state_o !== 2'd0) begin
      miscompares++;
      $display("FAIL basic_rearm: got state=%0d expected 0", state_o);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 48; i++) step(1'b1, 32'(4 * i), $urandom, i == 39, 1'b0);
    vectors++;
    if (count !== 5'd16 || state_o !== 2'd2) begin
      miscompares++;
      $display("FAIL wrap_full: got count=%0d state=%0d expected 16/2", count, state_o);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1);
    vectors++;
    if (rd_pc !== 32'd128) begin
      miscompares++;
      $display("FAIL wrap_first: got pc=%0d expected 128", rd_pc);
    end
    drain(15);
    vectors++;
    if (rd_pc !== 32'd188) begin
      miscompares++;
      $display("FAIL wrap_last: got pc=%0d expected 188", rd_pc);
    end
  endtask

  // Invalid gaps and stray triggers in POST/DONE
  task automatic test_gaps();
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, $urandom, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      for (int g = 0; g < 10; g++) step(1'b0, $urandom, $urandom, 1'(g == 3), 1'b0);
    end
    vectors++;
    if (state_o !== 2'd1 || count !== 5'd11) begin
      miscompares++;
      $display("FAIL gaps_post: got state=%0d count=%0d expected 1/11", state_o, count);
    end
    step(1'b1, $urandom, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'(i[0]), $urandom, $urandom, 1'b1, 1'b0);
    vectors++;
    if (state_o !== 2'd2 || count !== 5'd12) begin
      miscompares++;
      $display("FAIL gaps_done: got state=%0d count=%0d expected 2/12", state_o, count);
    end
  endtask

  // Pops in capture states are ignored; extra pops past empty do nothing
  task automatic test_reads();
    drain(12);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, $urandom, i == 2, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    apply_reset("mid_done");
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) apply_reset("random");
      step($urandom_range(0, 9) < 7, $urandom, $urandom,
           $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    model_clear();
    #12;
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_gaps();
    test_reads();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
